// File: rtl/word_uart_streamer.sv
`timescale 1ns/1ps
// word_uart_streamer
// Streams a block of 32-bit words from a synchronous-read memory to a
// byte-wide UART transmitter, least significant byte first, one byte in
// flight at a time.
//
// Ports
//   clk_in          single clock, all state on the rising edge
//   rst_in          asynchronous active-low reset
//   start_in        begin a transfer (honoured only while idle)
//   abort_in        cancel the transfer in progress, no done pulse
//   base_addr_in    first word address, sampled at start
//   num_words_in    number of words to send, sampled at start
//   addr_out        memory read address
//   word_in         memory read data, valid READ_LATENCY cycles after addr_out
//   tx_data_out     byte to the transmitter, held until the next trigger
//   tx_trigger_out  one-cycle send strobe
//   tx_busy_in      transmitter busy
//   busy_out        high whenever not idle
//   done_out        one-cycle pulse when a transfer completes
//
// state  | meaning
// IDLE   | waiting for start_in
// FETCH  | address held READ_LATENCY cycles, word captured on the last one
// SEND   | waiting for the transmitter to be free, then strobe one byte
// GAP    | one cycle for the transmitter to raise busy
// DRAIN  | waiting for the byte to finish, pick next byte/word or finish
// FINISH | done_out high for one cycle
module word_uart_streamer #(
    parameter int ADDR_WIDTH   = 16,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    input  logic                  abort_in,
    input  logic [ADDR_WIDTH-1:0] base_addr_in,
    input  logic [ADDR_WIDTH-1:0] num_words_in,
    output logic [ADDR_WIDTH-1:0] addr_out,
    input  logic [31:0]           word_in,
    output logic [7:0]            tx_data_out,
    output logic                  tx_trigger_out,
    input  logic                  tx_busy_in,
    output logic                  busy_out,
    output logic                  done_out
);

    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND,
        GAP,
        DRAIN,
        FINISH
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] num_q;
    // One bit wider than the count so a full 2^ADDR_WIDTH-1 transfer
    // can be compared without wrapping.
    logic [ADDR_WIDTH:0]   words_sent;
    logic [ADDR_WIDTH:0]   words_next;
    logic [1:0]            byte_idx;
    logic [LAT_W-1:0]      lat_cnt;
    logic [31:0]           word_q;

    assign words_next = words_sent + (ADDR_WIDTH+1)'(1);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state          <= IDLE;
            addr_out       <= '0;
            tx_data_out    <= '0;
            tx_trigger_out <= 1'b0;
            busy_out       <= 1'b0;
            done_out       <= 1'b0;
            num_q          <= '0;
            words_sent     <= '0;
            byte_idx       <= '0;
            lat_cnt        <= '0;
            word_q         <= '0;
        end else begin
            tx_trigger_out <= 1'b0;
            done_out       <= 1'b0;
            if (abort_in && state != IDLE) begin
                state    <= IDLE;
                busy_out <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_in) begin
                            num_q      <= num_words_in;
                            words_sent <= '0;
                            byte_idx   <= '0;
                            lat_cnt    <= '0;
                            busy_out   <= 1'b1;
                            // An empty transfer leaves the address untouched.
                            if (num_words_in == '0) begin
                                state    <= FINISH;
                                done_out <= 1'b1;
                            end else begin
                                addr_out <= base_addr_in;
                                state    <= FETCH;
                            end
                        end
                    end
                    FETCH: begin
                        if (lat_cnt == LAT_LAST) begin
                            word_q <= word_in;
                            state  <= SEND;
                        end else begin
                            lat_cnt <= lat_cnt + LAT_W'(1);
                        end
                    end
                    SEND: begin
                        if (!tx_busy_in) begin
                            tx_trigger_out <= 1'b1;
                            tx_data_out    <= word_q[{byte_idx, 3'b000} +: 8];
                            state          <= GAP;
                        end
                    end
                    GAP: begin
                        state <= DRAIN;
                    end
                    DRAIN: begin
                        if (!tx_busy_in) begin
                            if (byte_idx != 2'd3) begin
                                byte_idx <= byte_idx + 2'd1;
                                state    <= SEND;
                            end else begin
                                words_sent <= words_next;
                                byte_idx   <= '0;
                                if (words_next < {1'b0, num_q}) begin
                                    addr_out <= addr_out + ADDR_WIDTH'(1);
                                    lat_cnt  <= '0;
                                    state    <= FETCH;
                                end else begin
                                    state    <= FINISH;
                                    done_out <= 1'b1;
                                end
                            end
                        end
                    end
                    FINISH: begin
                        state    <= IDLE;
                        busy_out <= 1'b0;
                    end
                    default: begin
                        state    <= IDLE;
                        busy_out <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_word_uart_streamer.sv
`timescale 1ns/1ps
// Testbench for word_uart_streamer: two instances (16-bit and 4-bit
// address), memory and transmitter models, a byte/address scoreboard and
// a monitor that checks every trigger against the expected stream.
module tb_word_uart_streamer;

    localparam int AW = 16;
    localparam int BW = 4;

    logic clk_100mhz = 1'b0;
    always #5 clk_100mhz = ~clk_100mhz;

    logic rst_n = 1'b0;

    // instance A (16-bit addresses)
    logic          start_a = 1'b0, abort_a = 1'b0;
    logic [AW-1:0] base_a = '0, num_a = '0, addr_a;
    logic [31:0]   word_a;
    logic [7:0]    txd_a;
    logic          trig_a, txbusy_a, busy_a, done_a;

    // instance B (4-bit addresses)
    logic          start_b = 1'b0, abort_b = 1'b0;
    logic [BW-1:0] base_b = '0, num_b = '0, addr_b;
    logic [31:0]   word_b;
    logic [7:0]    txd_b;
    logic          trig_b, txbusy_b, busy_b, done_b;

    word_uart_streamer #(.ADDR_WIDTH(AW), .READ_LATENCY(2)) dut_a (
        .clk_in(clk_100mhz), .rst_in(rst_n), .start_in(start_a), .abort_in(abort_a),
        .base_addr_in(base_a), .num_words_in(num_a), .addr_out(addr_a), .word_in(word_a),
        .tx_data_out(txd_a), .tx_trigger_out(trig_a), .tx_busy_in(txbusy_a),
        .busy_out(busy_a), .done_out(done_a)
    );

    word_uart_streamer #(.ADDR_WIDTH(BW), .READ_LATENCY(2)) dut_b (
        .clk_in(clk_100mhz), .rst_in(rst_n), .start_in(start_b), .abort_in(abort_b),
        .base_addr_in(base_b), .num_words_in(num_b), .addr_out(addr_b), .word_in(word_b),
        .tx_data_out(txd_b), .tx_trigger_out(trig_b), .tx_busy_in(txbusy_b),
        .busy_out(busy_b), .done_out(done_b)
    );

    // memories: data valid two cycles after the address is presented
    logic [31:0] mem_a [0:(1<<AW)-1];
    logic [31:0] mem_b [0:(1<<BW)-1];
    always @(posedge clk_100mhz) word_a <= mem_a[addr_a];
    always @(posedge clk_100mhz) word_b <= mem_b[addr_b];

    // transmitters: busy for tx_len cycles after each trigger
    int   tx_len_a = 10, tx_cnt_a = 0, tx_len_b = 3, tx_cnt_b = 0;
    logic force_busy_a = 1'b0;
    always @(posedge clk_100mhz) begin
        if (trig_a) tx_cnt_a <= tx_len_a;
        else if (tx_cnt_a > 0) tx_cnt_a <= tx_cnt_a - 1;
        if (trig_b) tx_cnt_b <= tx_len_b;
        else if (tx_cnt_b > 0) tx_cnt_b <= tx_cnt_b - 1;
    end
    assign txbusy_a = (tx_cnt_a > 0) || force_busy_a;
    assign txbusy_b = (tx_cnt_b > 0);

    typedef struct packed {
        logic [7:0]  b;
        logic [15:0] a;
    } exp_t;
    exp_t exp_a[$];
    exp_t exp_b[$];

    int n_checks = 0, n_fail = 0;
    int trig_cnt_a = 0, done_cnt_a = 0, exp_trig_a = 0, exp_done_a = 0;
    int trig_cnt_b = 0, done_cnt_b = 0, exp_trig_b = 0, exp_done_b = 0;
    logic [7:0] last_a = 8'h00, last_b = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // monitor: every trigger must match the head of the expected stream
    always @(negedge clk_100mhz) begin
        exp_t e;
        if (!rst_n) begin
            last_a = 8'h00;
            last_b = 8'h00;
        end else begin
            if (trig_a) begin
                trig_cnt_a++;
                check("one_in_flight_a", 32'(txbusy_a), 32'd0);
                check("exp_avail_a", 32'(exp_a.size() > 0), 32'd1);
                if (exp_a.size() > 0) begin
                    e = exp_a.pop_front();
                    check("byte_a", 32'(txd_a), 32'(e.b));
                    check("addr_a", 32'(addr_a), 32'(e.a));
                end
                last_a = txd_a;
            end else begin
                check("txdata_stable_a", 32'(txd_a), 32'(last_a));
            end
            if (done_a) done_cnt_a++;
            if (trig_b) begin
                trig_cnt_b++;
                check("one_in_flight_b", 32'(txbusy_b), 32'd0);
                check("exp_avail_b", 32'(exp_b.size() > 0), 32'd1);
                if (exp_b.size() > 0) begin
                    e = exp_b.pop_front();
                    check("byte_b", 32'(txd_b), 32'(e.b));
                    check("addr_b", 32'(addr_b), 32'(e.a));
                end
                last_b = txd_b;
            end else begin
                check("txdata_stable_b", 32'(txd_b), 32'(last_b));
            end
            if (done_b) done_cnt_b++;
        end
    end

    // reference model: word i comes from (base+i) mod 2^AW, bytes LSB first
    task automatic start_xfer(input bit inst, input logic [15:0] base, input logic [15:0] num);
        exp_t        e;
        logic [31:0] w;
        logic [15:0] a;
        for (int i = 0; i < int'(num); i++) begin
            if (!inst) begin
                a = base + 16'(i);
                w = mem_a[a];
            end else begin
                a = {12'd0, 4'(base[3:0] + 4'(i))};
                w = mem_b[a[3:0]];
            end
            for (int k = 0; k < 4; k++) begin
                e.b = w[8*k +: 8];
                e.a = a;
                if (!inst) exp_a.push_back(e);
                else exp_b.push_back(e);
            end
        end
        if (!inst) begin
            exp_trig_a += 4 * int'(num);
            exp_done_a++;
            base_a  = base;
            num_a   = num;
            start_a = 1'b1;
        end else begin
            exp_trig_b += 4 * int'(num);
            exp_done_b++;
            base_b  = base[3:0];
            num_b   = num[3:0];
            start_b = 1'b1;
        end
        @(negedge clk_100mhz);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input bit inst, input int budget, input string name);
        int   n = 0;
        logic d;
        d = inst ? done_b : done_a;
        while (!d && n < budget) begin
            @(negedge clk_100mhz);
            n++;
            d = inst ? done_b : done_a;
        end
        check({name, "_done"}, 32'(d), 32'd1);
        check({name, "_drained"}, 32'(inst ? exp_b.size() : exp_a.size()), 32'd0);
        @(negedge clk_100mhz);
        check({name, "_busy_low"}, 32'(inst ? busy_b : busy_a), 32'd0);
        check({name, "_done_1cyc"}, 32'(inst ? done_b : done_a), 32'd0);
    endtask

    task automatic flush_a();
        exp_trig_a -= exp_a.size();
        exp_a.delete();
        exp_done_a--;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, seen, n, num;
        logic [15:0] base;

        for (int i = 0; i < (1 << AW); i++) mem_a[i] = $urandom;
        for (int i = 0; i < (1 << BW); i++) mem_b[i] = $urandom;
        mem_a[5] = 32'hDDCCBBAA;

        // reset values
        repeat (3) @(negedge clk_100mhz);
        check("rst_addr_a", 32'(addr_a), 32'd0);
        check("rst_txd_a", 32'(txd_a), 32'd0);
        check("rst_trig_a", 32'(trig_a), 32'd0);
        check("rst_busy_a", 32'(busy_a), 32'd0);
        check("rst_done_a", 32'(done_a), 32'd0);
        check("rst_busy_b", 32'(busy_b), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_100mhz);

        // single word, slow transmitter
        t0 = trig_cnt_a;
        start_xfer(0, 16'd5, 16'd1);
        wait_done(0, 200, "word5");
        check("word5_triggers", 32'(trig_cnt_a - t0), 32'd4);

        // empty transfer
        t0 = trig_cnt_a;
        start_xfer(0, 16'h1234, 16'd0);
        check("num0_done_cycle2", 32'(done_a), 32'd1);
        check("num0_addr_kept", 32'(addr_a), 32'd5);
        @(negedge clk_100mhz);
        check("num0_done_low", 32'(done_a), 32'd0);
        check("num0_busy_low", 32'(busy_a), 32'd0);
        check("num0_no_trigger", 32'(trig_cnt_a - t0), 32'd0);

        // transmitter busy at start, start re-pulsed mid-transfer
        force_busy_a = 1'b1;
        t0 = trig_cnt_a;
        start_xfer(0, 16'h0200, 16'd2);
        repeat (50) @(negedge clk_100mhz);
        check("held_busy_no_trigger", 32'(trig_cnt_a - t0), 32'd0);
        force_busy_a = 1'b0;
        n = 0;
        while (!trig_a && n < 20) begin @(negedge clk_100mhz); n++; end
        check("trigger_after_release", 32'(trig_a), 32'd1);
        start_a = 1'b1; base_a = 16'h0100; num_a = 16'd7;
        @(negedge clk_100mhz);
        start_a = 1'b0;
        wait_done(0, 400, "restart_ignored");

        // abort after the second byte of three words
        start_xfer(0, 16'h0300, 16'd3);
        seen = 0; n = 0;
        while (seen < 2 && n < 200) begin
            @(negedge clk_100mhz);
            n++;
            if (trig_a) seen++;
        end
        check("abort_two_bytes_seen", 32'(seen), 32'd2);
        t0 = done_cnt_a;
        abort_a = 1'b1;
        @(negedge clk_100mhz);
        abort_a = 1'b0;
        check("abort_busy_low", 32'(busy_a), 32'd0);
        check("abort_trig_low", 32'(trig_a), 32'd0);
        flush_a();
        repeat (40) @(negedge clk_100mhz);
        check("abort_no_done", 32'(done_cnt_a - t0), 32'd0);
        start_xfer(0, 16'h0400, 16'd1);
        wait_done(0, 200, "after_abort");

        // reset during GAP (the trigger cycle)
        start_xfer(0, 16'h0500, 16'd2);
        n = 0;
        while (!trig_a && n < 200) begin @(negedge clk_100mhz); n++; end
        check("gap_reached", 32'(trig_a), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_addr", 32'(addr_a), 32'd0);
        check("async_rst_txd", 32'(txd_a), 32'd0);
        check("async_rst_trig", 32'(trig_a), 32'd0);
        check("async_rst_busy", 32'(busy_a), 32'd0);
        check("async_rst_done", 32'(done_a), 32'd0);
        flush_a();
        t0 = done_cnt_a;
        repeat (2) @(negedge clk_100mhz);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_100mhz);
        check("rst_no_done", 32'(done_cnt_a - t0), 32'd0);
        start_xfer(0, 16'h0600, 16'd1);
        wait_done(0, 200, "after_reset");

        // randomized transfers, including address wrap near the top
        for (int r = 0; r < 8; r++) begin
            tx_len_a = $urandom_range(0, 12);
            num      = $urandom_range(1, 4);
            base     = (r % 3 == 0) ? 16'(16'hFFFE + 16'($urandom_range(0, 1))) : 16'($urandom);
            start_xfer(0, base, 16'(num));
            wait_done(0, num * 4 * (tx_len_a + 8) + 40, "random_a");
        end

        // 4-bit address: wrap 15 -> 0, then maximum word count
        t0 = trig_cnt_b;
        start_xfer(1, 16'd15, 16'd2);
        wait_done(1, 200, "wrap_b");
        check("wrap_b_bytes", 32'(trig_cnt_b - t0), 32'd8);
        t0 = trig_cnt_b;
        start_xfer(1, 16'($urandom_range(0, 15)), 16'd15);
        wait_done(1, 1500, "max_b");
        check("max_b_bytes", 32'(trig_cnt_b - t0), 32'd60);

        repeat (5) @(negedge clk_100mhz);
        check("total_triggers_a", 32'(trig_cnt_a), 32'(exp_trig_a));
        check("total_done_a", 32'(done_cnt_a), 32'(exp_done_a));
        check("total_triggers_b", 32'(trig_cnt_b), 32'(exp_trig_b));
        check("total_done_b", 32'(done_cnt_b), 32'(exp_done_b));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
